// File: rtl/csr_access_ctrl.sv
// Zicsr read-modify-write sequencer for a single-port machine CSR file.
// It also arbitrates the CSR port between execute-stage accesses and trap-entry writes.
module csr_access_ctrl #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_op_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic              req_nowr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_illegal_o,
  input  logic              trap_valid_i,
  output logic              trap_ready_o,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic [XLEN-1:0]   trap_wdata_i,
  output logic [ADDR_W-1:0] csr_addr_o,
  output logic              csr_re_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic              csr_we_o,
  output logic [XLEN-1:0]   csr_wdata_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_e;

  localparam logic [1:0] OP_RW  = 2'b00;
  localparam logic [1:0] OP_RS  = 2'b01;
  localparam logic [1:0] OP_RC  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              nowr_q, nowr_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic              illegal_q, illegal_d;

  logic              req_impl;
  logic              req_wr_needed;
  logic              req_illegal;
  logic              lat_wr_needed;
  logic [XLEN-1:0]   new_val;

  assign req_impl = req_addr_i inside {
    [12'h001:12'h003], [12'hC00:12'hC02], [12'hC80:12'hC82], [12'hF11:12'hF14],
    [12'h300:12'h306], [12'h340:12'h344], 12'hB00, 12'hB02
  };

  // RS/RC with x0/uimm=0 are pure reads, so they may target read-only CSRs.
  assign req_wr_needed = (req_op_i == OP_RW) || !req_nowr_i;
  assign req_illegal   = (req_op_i == OP_RSV) || !req_impl ||
                         ((req_addr_i[ADDR_W-1 -: 2] == 2'b11) && req_wr_needed);
  assign lat_wr_needed = (op_q == OP_RW) || !nowr_q;

  always_comb begin
    unique case (op_q)
      OP_RS:   new_val = old_q | wdata_q;
      OP_RC:   new_val = old_q & ~wdata_q;
      default: new_val = wdata_q;
    endcase
  end

  always_comb begin
    // NOTE: every combinational output and next-state gets a default here so no
    // path through the case below can leave a signal unassigned and infer a latch.
    state_d       = state_q;
    addr_d        = addr_q;
    op_d          = op_q;
    wdata_d       = wdata_q;
    nowr_d        = nowr_q;
    old_d         = old_q;
    illegal_d     = illegal_q;
    req_ready_o   = 1'b0;
    rsp_valid_o   = 1'b0;
    rsp_rdata_o   = '0;
    rsp_illegal_o = 1'b0;
    trap_ready_o  = 1'b0;
    csr_addr_o    = '0;
    csr_re_o      = 1'b0;
    csr_we_o      = 1'b0;
    csr_wdata_o   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (trap_valid_i) begin
          trap_ready_o = 1'b1;
          csr_we_o     = 1'b1;
          csr_addr_o   = trap_addr_i;
          csr_wdata_o  = trap_wdata_i;
        end else if (req_valid_i) begin
          req_ready_o = 1'b1;
          addr_d      = req_addr_i;
          op_d        = req_op_i;
          wdata_d     = req_wdata_i;
          nowr_d      = req_nowr_i;
          old_d       = '0;
          illegal_d   = req_illegal;
          if (req_illegal) begin
            state_d = S_RESP;
          end else begin
            csr_re_o   = 1'b1;
            csr_addr_o = req_addr_i;
            state_d    = S_READ;
          end
        end
      end
      S_READ: begin
        csr_addr_o = addr_q;
        old_d      = csr_rdata_i;
        state_d    = lat_wr_needed ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = addr_q;
        csr_wdata_o = new_val;
        state_d     = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o   = 1'b1;
        rsp_rdata_o   = old_q;
        rsp_illegal_o = illegal_q;
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      op_q      <= '0;
      wdata_q   <= '0;
      nowr_q    <= 1'b0;
      old_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      wdata_q   <= wdata_d;
      nowr_q    <= nowr_d;
      old_q     <= old_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: emulates the CSR file and predicts each
// access from the ISA-level rules (legality, old value, new value, latency).
module tb_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [11:0] req_addr_i = '0;
  logic [1:0]  req_op_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        req_nowr_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_illegal_o;
  logic        trap_valid_i = 1'b0;
  logic        trap_ready_o;
  logic [11:0] trap_addr_i = '0;
  logic [31:0] trap_wdata_i = '0;
  logic [11:0] csr_addr_o;
  logic        csr_re_o;
  logic [31:0] csr_rdata_i = '0;
  logic        csr_we_o;
  logic [31:0] csr_wdata_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int re_cnt = 0;
  int we_cnt = 0;
  int both_cnt = 0;
  logic [11:0] last_we_addr = '0;
  logic [31:0] last_we_data = '0;
  logic [31:0] file_mem [4096];
  logic [31:0] exp_mem [4096];

  localparam int NRANGE = 8;
  localparam int LO [NRANGE] = '{'h001, 'hC00, 'hC80, 'hF11, 'h300, 'h340, 'hB00, 'hB02};
  localparam int HI [NRANGE] = '{'h003, 'hC02, 'hC82, 'hF14, 'h306, 'h344, 'hB00, 'hB02};

  csr_access_ctrl #(.XLEN(32), .ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_op_i(req_op_i), .req_wdata_i(req_wdata_i), .req_nowr_i(req_nowr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_illegal_o(rsp_illegal_o),
    .trap_valid_i(trap_valid_i), .trap_ready_o(trap_ready_o), .trap_addr_i(trap_addr_i),
    .trap_wdata_i(trap_wdata_i),
    .csr_addr_o(csr_addr_o), .csr_re_o(csr_re_o), .csr_rdata_i(csr_rdata_i),
    .csr_we_o(csr_we_o), .csr_wdata_o(csr_wdata_o)
  );

  always #5 clk = ~clk;

  // CSR file emulator and strobe monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (csr_re_o) begin
      csr_rdata_i <= file_mem[csr_addr_o];
      re_cnt      <= re_cnt + 1;
    end
    if (csr_we_o) begin
      file_mem[csr_addr_o] = csr_wdata_o;
      we_cnt       <= we_cnt + 1;
      last_we_addr <= csr_addr_o;
      last_we_data <= csr_wdata_o;
    end
    if (csr_re_o && csr_we_o) both_cnt <= both_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic bit is_impl(input logic [11:0] a);
    for (int i = 0; i < NRANGE; i++)
      if (int'(a) >= LO[i] && int'(a) <= HI[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [71:0] all_outputs();
    return {req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_illegal_o, trap_ready_o,
            csr_addr_o, csr_re_o, csr_we_o, csr_wdata_o, 3'b000};
  endfunction

  task automatic do_req(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                        input logic nowr, input int hold);
    bit          wn, legal;
    logic [31:0] old_v, new_v, rd_seen;
    int          exp_lat, lat, c0, re0, we0;
    wn    = (op == 2'b00) || !nowr;
    legal = (op != 2'b11) && is_impl(a) && !(a[11:10] == 2'b11 && wn);
    old_v = legal ? exp_mem[a] : 32'h0;
    case (op)
      2'b01:   new_v = old_v | wd;
      2'b10:   new_v = old_v & ~wd;
      default: new_v = wd;
    endcase
    exp_lat = !legal ? 1 : (wn ? 3 : 2);

    @(negedge clk);
    re0 = re_cnt;
    we0 = we_cnt;
    req_valid_i = 1'b1; req_addr_i = a; req_op_i = op; req_wdata_i = wd; req_nowr_i = nowr;
    rsp_ready_i = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL req_ready addr=%h got %b expected 1", a, req_ready_o);
    end
    c0 = cyc;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_wdata_i = $urandom;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid_o === 1'b1) begin
        lat = cyc - c0;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL latency addr=%h op=%0d got %0d expected %0d", a, op, lat, exp_lat);
    end
    if (lat < 0) return;
    checks++;
    if (rsp_rdata_o !== old_v) begin
      errors++; $display("FAIL rsp_rdata addr=%h got %h expected %h", a, rsp_rdata_o, old_v);
    end
    checks++;
    if (rsp_illegal_o !== !legal) begin
      errors++; $display("FAIL rsp_illegal addr=%h op=%0d got %b expected %b", a, op, rsp_illegal_o, !legal);
    end
    rd_seen = rsp_rdata_o;
    for (int i = 0; i < hold; i++) begin
      req_valid_i = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== rd_seen || req_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL rsp_hold cycle %0d got valid=%b rdata=%h ready=%b expected 1/%h/0",
                 i, rsp_valid_o, rsp_rdata_o, req_ready_o, rd_seen);
      end
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b0) begin
      errors++; $display("FAIL rsp_drop got %b expected 0", rsp_valid_o);
    end
    checks++;
    if (re_cnt - re0 != int'(legal)) begin
      errors++; $display("FAIL re_count addr=%h got %0d expected %0d", a, re_cnt - re0, int'(legal));
    end
    checks++;
    if (we_cnt - we0 != int'(legal && wn)) begin
      errors++; $display("FAIL we_count addr=%h got %0d expected %0d", a, we_cnt - we0, int'(legal && wn));
    end
    if (legal && wn) begin
      checks++;
      if (last_we_addr !== a || last_we_data !== new_v) begin
        errors++;
        $display("FAIL we_data got %h:%h expected %h:%h", last_we_addr, last_we_data, a, new_v);
      end
      exp_mem[a] = new_v;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outputs() !== '0) begin
      errors++; $display("FAIL reset_outputs got %h expected 0", all_outputs());
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (all_outputs() !== '0) begin
      errors++; $display("FAIL idle_outputs got %h expected 0", all_outputs());
    end
  endtask

  task automatic test_directed();
    file_mem[12'h340] = 32'h1234;     exp_mem[12'h340] = 32'h1234;
    do_req(12'h340, 2'b00, 32'hDEAD_BEEF, 1'b0, 0);
    checks++;
    if (file_mem[12'h340] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rw_340 got %h expected deadbeef", file_mem[12'h340]);
    end
    file_mem[12'h304] = 32'h0008;     exp_mem[12'h304] = 32'h0008;
    do_req(12'h304, 2'b01, 32'h0880, 1'b0, 0);
    checks++;
    if (file_mem[12'h304] !== 32'h0888) begin
      errors++; $display("FAIL rs_304 got %h expected 00000888", file_mem[12'h304]);
    end
    file_mem[12'h300] = 32'h00FF;     exp_mem[12'h300] = 32'h00FF;
    do_req(12'h300, 2'b10, 32'h000F, 1'b0, 0);
    checks++;
    if (file_mem[12'h300] !== 32'h00F0) begin
      errors++; $display("FAIL rc_300 got %h expected 000000f0", file_mem[12'h300]);
    end
    do_req(12'hC00, 2'b01, 32'h0, 1'b1, 0);      // read-only CSR, pure read
    do_req(12'hC00, 2'b00, 32'h5, 1'b0, 0);      // write to read-only
    do_req(12'hC00, 2'b01, 32'h5, 1'b0, 0);
    do_req(12'hF11, 2'b00, 32'h1, 1'b1, 0);      // RW writes even with nowr
    do_req(12'h7C0, 2'b00, 32'h1, 1'b0, 0);
    do_req(12'h340, 2'b11, 32'h1, 1'b0, 0);
    do_req(12'hF14, 2'b10, 32'h0, 1'b1, 0);
    do_req(12'hF15, 2'b10, 32'h0, 1'b1, 0);
    do_req(12'h307, 2'b00, 32'h3, 1'b0, 0);
    do_req(12'h000, 2'b01, 32'h3, 1'b1, 0);
    do_req(12'hB01, 2'b00, 32'h3, 1'b0, 0);
    do_req(12'hB02, 2'b01, 32'h3, 1'b1, 0);
    do_req(12'h344, 2'b01, 32'hA5A5_0000, 1'b0, 5);
  endtask

  task automatic test_trap_priority();
    @(negedge clk);
    trap_valid_i = 1'b1; trap_addr_i = 12'h341; trap_wdata_i = 32'h8000_0123;
    req_valid_i = 1'b1; req_addr_i = 12'h340; req_op_i = 2'b00; req_wdata_i = 32'h77; req_nowr_i = 1'b0;
    #1;
    checks++;
    if (trap_ready_o !== 1'b1 || csr_we_o !== 1'b1 || csr_addr_o !== 12'h341 ||
        csr_wdata_o !== 32'h8000_0123 || req_ready_o !== 1'b0 || csr_re_o !== 1'b0) begin
      errors++;
      $display("FAIL trap_first got tr=%b we=%b a=%h d=%h rr=%b re=%b expected 1/1/341/80000123/0/0",
               trap_ready_o, csr_we_o, csr_addr_o, csr_wdata_o, req_ready_o, csr_re_o);
    end
    @(negedge clk);
    trap_valid_i = 1'b0;
    exp_mem[12'h341] = 32'h8000_0123;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || trap_ready_o !== 1'b0) begin
      errors++; $display("FAIL req_after_trap got rr=%b tr=%b expected 1/0", req_ready_o, trap_ready_o);
    end
    req_valid_i = 1'b0;
    checks++;
    if (file_mem[12'h341] !== 32'h8000_0123) begin
      errors++; $display("FAIL trap_write got %h expected 80000123", file_mem[12'h341]);
    end
    do_req(12'h340, 2'b00, 32'h77, 1'b0, 0);
  endtask

  task automatic test_trap_mid();
    logic [31:0] rs_new;
    int          trap_seen;
    rs_new = exp_mem[12'h305] | 32'h0000_1100;
    @(negedge clk);
    req_valid_i = 1'b1; req_addr_i = 12'h305; req_op_i = 2'b01; req_wdata_i = 32'h0000_1100; req_nowr_i = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b0;
    trap_valid_i = 1'b1; trap_addr_i = 12'h343; trap_wdata_i = 32'hCAFE_0001;
    trap_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (trap_ready_o !== 1'b0) trap_seen++;
      if (rsp_valid_o === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (trap_seen != 0 || rsp_valid_o !== 1'b1) begin
      errors++; $display("FAIL trap_wait got trap_ready cycles=%0d rsp=%b expected 0/1", trap_seen, rsp_valid_o);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    checks++;
    if (trap_ready_o !== 1'b1 || csr_addr_o !== 12'h343 || csr_we_o !== 1'b1) begin
      errors++; $display("FAIL trap_after_resp got tr=%b a=%h we=%b expected 1/343/1",
                         trap_ready_o, csr_addr_o, csr_we_o);
    end
    @(negedge clk);
    trap_valid_i = 1'b0;
    exp_mem[12'h305] = rs_new;
    exp_mem[12'h343] = 32'hCAFE_0001;
    checks++;
    if (file_mem[12'h305] !== rs_new || file_mem[12'h343] !== 32'hCAFE_0001) begin
      errors++; $display("FAIL trap_mid_mem got %h/%h expected %h/cafe0001",
                         file_mem[12'h305], file_mem[12'h343], rs_new);
    end
  endtask

  task automatic test_reset_mid();
    int we0;
    @(negedge clk);
    req_valid_i = 1'b1; req_addr_i = 12'h342; req_op_i = 2'b00; req_wdata_i = 32'h1357_9BDF; req_nowr_i = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (csr_we_o !== 1'b1) begin
      errors++; $display("FAIL write_state got we=%b expected 1", csr_we_o);
    end
    we0 = we_cnt;
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      errors++; $display("FAIL reset_in_write got %h expected 0", all_outputs());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (we_cnt != we0 || file_mem[12'h342] !== exp_mem[12'h342] || rsp_valid_o !== 1'b0) begin
      errors++; $display("FAIL write_dropped got we=%0d mem=%h rsp=%b expected %0d/%h/0",
                         we_cnt, file_mem[12'h342], rsp_valid_o, we0, exp_mem[12'h342]);
    end
    do_req(12'h342, 2'b00, 32'h2468_ACE0, 1'b0, 1);
  endtask

  task automatic test_random();
    logic [11:0] a;
    int          r;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        a = 12'($urandom);
      end else begin
        r = $urandom_range(0, NRANGE - 1);
        a = 12'(LO[r] + $urandom_range(0, HI[r] - LO[r]));
      end
      do_req(a, 2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 2) == 0), $urandom_range(0, 2));
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      file_mem[i] = $urandom;
      exp_mem[i]  = file_mem[i];
    end
    test_reset();
    test_directed();
    test_trap_priority();
    test_trap_mid();
    test_reset_mid();
    test_random();
    checks++;
    if (both_cnt != 0) begin
      errors++; $display("FAIL re_we_overlap got %0d cycles expected 0", both_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
